// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
//   opcode_e : binary operation select (ADD..MUL)
//   state_e  : control FSM states
//   FLAG_*   : bit positions inside the 5-bit flags word {err, ovf, neg, carry, zero}
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_INC = 3'd2,
        OP_DEC = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_NOT = 3'd6,
        OP_MUL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_W     = 5;
    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned FLAG_OVF   = 3;
    localparam int unsigned FLAG_ERR   = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier taking WIDTH clock edges per product.
// The start edge already performs the first partial-product step, so done
// pulses for one cycle WIDTH-1 edges after start with prod valid alongside it.
//   clk, rst   : clock, synchronous active-high reset (aborts any product)
//   start      : load a/b and begin
//   a, b       : WIDTH-bit unsigned operands
//   done       : one-cycle pulse, prod holds the full product
//   prod       : 2*WIDTH-bit product
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             busy;

    // One partial product per edge; multiplier bits consumed LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= b[0] ? PW'(a) : '0;
                mcand  <= PW'(a) << 1;
                mplier <= b >> 1;
                cnt    <= CW'(1);
                busy   <= 1'b1;
            end else if (busy) begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign prod = acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on request and result sides.
// Opcodes 0-6 complete in one cycle and can stream one per cycle; MUL uses a
// WIDTH-cycle shift-add multiplier when SEQ_ALU_MUL_EN is defined, otherwise
// opcode 7 returns an illegal-op result (err=1, zero=1) with latency 1.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : request handshake (op1, op2, opcode)
//   out_valid/out_ready : result handshake (result, result_hi, flags)
//   flags             : {err, ovf, neg, carry, zero}
// Configuration macro: SEQ_ALU_MUL_EN
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    input  logic [2:0]        opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output logic [FLAG_W-1:0] flags
);

    localparam int unsigned SW = WIDTH + 1;

    state_e           state;
    opcode_e          op;
    logic             accept;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] alu_res;
    logic [FLAG_W-1:0] alu_flags;

    assign op       = opcode_e'(opcode);
    assign in_ready = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath; ADD/SUB/INC/DEC share one WIDTH+1-bit adder.
    always_comb begin
        add_b     = '0;
        add_cin   = 1'b0;
        alu_res   = '0;
        alu_flags = '0;
        case (op)
            OP_ADD:  add_b = op2;
            OP_SUB:  begin add_b = ~op2; add_cin = 1'b1; end
            OP_INC:  add_b = WIDTH'(1);
            OP_DEC:  add_b = '1;
            default: add_b = '0;
        endcase
        sum = {1'b0, op1} + {1'b0, add_b} + SW'(add_cin);
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                alu_res               = sum[WIDTH-1:0];
                alu_flags[FLAG_CARRY] = sum[WIDTH];
                // Signed overflow: same-sign inputs producing a different-sign sum.
                alu_flags[FLAG_OVF]   = (op1[WIDTH-1] == add_b[WIDTH-1]) &&
                                        (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_NOT:  alu_res = ~op1;
            default: alu_flags[FLAG_ERR] = 1'b1;   // opcode 7 without multiplier
        endcase
        alu_flags[FLAG_ZERO] = (alu_res == '0);
        alu_flags[FLAG_NEG]  = alu_res[WIDTH-1];
    end

`ifdef SEQ_ALU_MUL_EN
    logic              mul_start;
    logic              mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]  mul_lo;
    logic [WIDTH-1:0]  mul_hi;
    logic [FLAG_W-1:0] mul_flags;

    assign mul_start = accept && (op == OP_MUL);
    assign mul_lo    = mul_prod[WIDTH-1:0];
    assign mul_hi    = mul_prod[2*WIDTH-1:WIDTH];

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (op1),
        .b     (op2),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Product flags: carry marks a non-zero high word.
    always_comb begin
        mul_flags             = '0;
        mul_flags[FLAG_ZERO]  = (mul_prod == '0);
        mul_flags[FLAG_NEG]   = mul_lo[WIDTH-1];
        mul_flags[FLAG_CARRY] = (mul_hi != '0);
    end
`endif

    // Control FSM and result registers; an accept in DONE retires and reloads in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else if (accept) begin
`ifdef SEQ_ALU_MUL_EN
            if (op == OP_MUL) begin
                state     <= ST_BUSY;
                out_valid <= 1'b0;
            end else
`endif
            begin
                state     <= ST_DONE;
                out_valid <= 1'b1;
                result    <= alu_res;
                result_hi <= '0;
                flags     <= alu_flags;
            end
        end else begin
            case (state)
                ST_BUSY: begin
`ifdef SEQ_ALU_MUL_EN
                    if (mul_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= mul_lo;
                        result_hi <= mul_hi;
                        flags     <= mul_flags;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed corner cases plus a
// randomized run scored against a cycle-level handshake/arithmetic model.
// Honours SEQ_ALU_MUL_EN the same way the design does.
module tb_seq_alu;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [4:0]   flags;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic: returns {hi, lo, err, ovf, neg, carry, zero}.
    function automatic logic [2*W+4:0] ref_op(input int op, input int a, input int b);
        int r, hi, sa, sb, sr;
        bit c, v, e, z, n;
        r = 0; hi = 0; sr = 0; c = 0; v = 0; e = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: begin r = a + b; c = (r > 255); sr = sa + sb; end
            1: begin r = a - b; c = (a >= b);  sr = sa - sb; end
            2: begin r = a + 1; c = (a == 255); sr = sa + 1; end
            3: begin r = a - 1; c = (a != 0);  sr = sa - 1; end
            4: r = a & b;
            5: r = a | b;
            6: r = 255 - a;
            default: begin
`ifdef SEQ_ALU_MUL_EN
                r  = (a * b) % 256;
                hi = (a * b) / 256;
                c  = (hi != 0);
`else
                e = 1;
`endif
            end
        endcase
        if (op <= 3) v = (sr > 127) || (sr < -128);
        r = r & 255;
        z = (r == 0) && (hi == 0);
        n = (r >= 128);
        return {W'(hi), W'(r), e, v, n, c, z};
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corner [5];
        corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return W'($urandom_range(0, 255));
    endfunction

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 3'd0;
        op1       = '0;
        op2       = '0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if ({out_valid, result, result_hi, flags} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b r=%h hi=%h f=%b want all 0", out_valid, result, result_hi, flags);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_wrap();
        in_valid = 1'b1; opcode = 3'd0; op1 = 8'hFF; op2 = 8'h01; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h00 || result_hi !== 8'h00 || flags !== 5'b00011) begin
            errors++;
            $display("FAIL add_wrap got v=%b r=%h hi=%h f=%b want v=1 r=00 hi=00 f=00011", out_valid, result, result_hi, flags);
        end
        drain();
    endtask

    task automatic test_sub_ovf();
        in_valid = 1'b1; opcode = 3'd1; op1 = 8'h80; op2 = 8'h01; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h7F || flags !== 5'b01010) begin
            errors++;
            $display("FAIL sub_ovf got v=%b r=%h f=%b want v=1 r=7f f=01010", out_valid, result, flags);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; opcode = 3'd2; op1 = 8'h7F; op2 = 8'h00; out_ready = 1'b1;
        tick();
        opcode = 3'd3; op1 = 8'h00;
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h80 || flags !== 5'b01100 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_inc got v=%b r=%h f=%b rdy=%b want v=1 r=80 f=01100 rdy=1", out_valid, result, flags, in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'hFF || flags !== 5'b00100) begin
            errors++;
            $display("FAIL b2b_dec got v=%b r=%h f=%b want v=1 r=ff f=00100", out_valid, result, flags);
        end
        tick();
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_retire got v=%b want 0", out_valid); end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; opcode = 3'd4; op1 = 8'hF0; op2 = 8'h3C; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; opcode = 3'(i); op1 = pick(); op2 = pick();
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 8'h30 || result_hi !== 8'h00 ||
                flags !== 5'b00000 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got v=%b r=%h hi=%h f=%b rdy=%b want v=1 r=30 hi=00 f=00000 rdy=0",
                         i, out_valid, result, result_hi, flags, in_ready);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_mul();
        in_valid = 1'b1; opcode = 3'd7; op1 = 8'hFF; op2 = 8'hFF; out_ready = 1'b0;
        tick();
`ifdef SEQ_ALU_MUL_EN
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; opcode = 3'd0;
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy_cycle%0d got v=%b rdy=%b want v=0 rdy=0", i, out_valid, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h01 || result_hi !== 8'hFE || flags !== 5'b00010) begin
            errors++;
            $display("FAIL mul_result got v=%b r=%h hi=%h f=%b want v=1 r=01 hi=fe f=00010", out_valid, result, result_hi, flags);
        end
`else
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h00 || result_hi !== 8'h00 || flags !== 5'b10001) begin
            errors++;
            $display("FAIL mul_illegal got v=%b r=%h hi=%h f=%b want v=1 r=00 hi=00 f=10001", out_valid, result, result_hi, flags);
        end
`endif
        drain();
    endtask

    task automatic test_reset_mid();
`ifdef SEQ_ALU_MUL_EN
        in_valid = 1'b1; opcode = 3'd7; op1 = pick(); op2 = pick(); out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
`else
        in_valid = 1'b1; opcode = 3'd0; op1 = 8'h12; op2 = 8'h34; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick();
`endif
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got %b want 0", in_ready); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, result, result_hi, flags} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_outputs got v=%b r=%h hi=%h f=%b rdy=%b want zeros rdy=1",
                     out_valid, result, result_hi, flags, in_ready);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_abort got v=%b want 0", out_valid); end
    endtask

    // Random traffic against a model of the handshake timing and a result queue.
    task automatic test_random();
        bit              have;
        int              busy_left;
        logic [2*W+4:0]  cur, pend, got;
        bit              exp_ready, acc;
        have = 0; busy_left = 0; cur = '0; pend = '0;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            opcode    = 3'($urandom_range(0, 7));
            op1       = pick();
            op2       = pick();
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = (busy_left == 0) && (!have || out_ready);
            checks++;
            if (in_ready !== exp_ready || out_valid !== have) begin
                errors++;
                $display("FAIL rand_hs cyc%0d got rdy=%b v=%b want rdy=%b v=%b", i, in_ready, out_valid, exp_ready, have);
            end
            if (have) begin
                got = {result_hi, result, flags};
                checks++;
                if (got !== cur) begin
                    errors++;
                    $display("FAIL rand_data cyc%0d got %h want %h", i, got, cur);
                end
            end
            acc = in_valid && exp_ready;
            if (have && out_ready) have = 0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin have = 1; cur = pend; end
            end
            if (acc) begin
`ifdef SEQ_ALU_MUL_EN
                if (opcode == 3'd7) begin
                    busy_left = W;
                    pend = ref_op(int'(opcode), int'(op1), int'(op2));
                end else
`endif
                begin
                    have = 1;
                    cur  = ref_op(int'(opcode), int'(op1), int'(op2));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_add_wrap();
        test_sub_ovf();
        test_back_to_back();
        test_hold();
        test_mul();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port op1  input  WIDTH  first operand.
REQ-007 SHALL have port op2  input  WIDTH  second operand.
REQ-008 SHALL have port opcode  input  3  operation select, binary encoded.
REQ-009 SHALL have port out_valid  output  1  result registers hold a valid result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port result  output  WIDTH  low result word.
REQ-012 SHALL have port result_hi  output  WIDTH  high product word; 0 for non-multiply ops.
REQ-013 SHALL have port flags  output  5  {err, ovf, neg, carry, zero}, MSB first.

Function
REQ-014 SHALL decode opcode as: 0 ADD op1+op2, 1 SUB op1-op2, 2 INC op1+1, 3 DEC op1-1, 4 AND, 5 OR, 6 NOT op1, 7 MUL op1*op2 (unsigned).
REQ-015 SHALL compute ADD/SUB/INC/DEC through one shared WIDTH+1-bit adder: SUB uses ~op2 with carry-in 1, INC uses constant 1, DEC uses all-ones.
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE: IDLE->DONE on accept of opcode 0-6, IDLE->BUSY on accept of MUL, BUSY->DONE after the last multiply step, DONE->IDLE on out_ready without a new accept.
REQ-017 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready); an accept occurs when in_valid and in_ready are both 1.
REQ-018 SHALL register results of opcodes 0-6 on the accept edge, giving out_valid=1 on the next cycle (latency 1).
REQ-019 SHALL, on accept while in DONE with out_ready=1, retire the old result and load the new one in the same edge, sustaining one op per cycle for opcodes 0-6.
REQ-020 SHALL hold result, result_hi, flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL set zero = (result==0 and result_hi==0) and neg = result[WIDTH-1] for every op.
REQ-022 SHALL set carry = adder carry-out for 0-3 (SUB: 1 means no borrow), carry = (result_hi!=0) for MUL, 0 for 4-6.
REQ-023 SHALL set ovf = signed overflow for ADD/SUB/INC/DEC, 0 otherwise.
REQ-024 SHALL ignore in_valid while in BUSY (in_ready=0) and ignore out_ready while out_valid=0.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, force state IDLE, out_valid 0, result 0, result_hi 0, flags 0, and abort any in-progress multiply.
REQ-026 SHALL hold in_ready=0 while rst=1 and drive in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL compile the multiplier only when macro SEQ_ALU_MUL_EN is defined: MUL is a WIDTH-cycle shift-add, so out_valid rises WIDTH+1 cycles after accept.
REQ-028 SHALL, without SEQ_ALU_MUL_EN, treat opcode 7 as illegal: latency 1, result 0, result_hi 0, flags = err=1 and zero=1, all other bits 0; BUSY is never entered.

Structure
REQ-029 SHALL take the opcode enum, FSM state typedef and flag bit-index constants from shared package alu_pkg.
REQ-030 SHALL place the shift-add multiplier in sub-module alu_mul_seq (start, done, WIDTH-parameterised), instantiated only under SEQ_ALU_MUL_EN.

Verification (WIDTH=8)
REQ-031 SHALL cover ADD 0xFF+0x01 -> result 0x00, zero=1, carry=1, ovf=0, out_valid one cycle after accept.
REQ-032 SHALL cover SUB 0x80-0x01 -> result 0x7F, carry=1, ovf=1, neg=0.
REQ-033 SHALL cover back-to-back INC 0x7F, DEC 0x00 with out_ready=1 -> consecutive results 0x80 (ovf=1, neg=1) then 0xFF (carry=0), one per cycle.
REQ-034 SHALL cover AND 0xF0&0x3C held with out_ready=0 for 3 cycles -> result 0x30 stable and in_ready=0 throughout.
REQ-035 SHALL cover MUL 0xFF*0xFF: with SEQ_ALU_MUL_EN -> result 0x01, result_hi 0xFE, carry=1, after 9 cycles; without it -> err=1, result 0 after 1 cycle.
REQ-036 SHALL cover rst pulse in the 4th BUSY cycle -> out_valid 0, all outputs 0, in_ready 1 on the cycle after rst deasserts.
